reg_writeback_queue: RTL and testbench

//  Write-side partner of the 32x32 register file. Accepts ALU and load results over

---
 rtl/reg_writeback_queue_if.sv | 39 +++
 rtl/reg_writeback_queue.sv | 110 +++++++++++
 tb/tb_reg_writeback_queue.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_if.sv
// Handshake and register-file bus between the result producers, the register
// file and reg_writeback_queue.
interface reg_writeback_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          AluValid;
  logic          AluReady;
  logic [AW-1:0] AluReg;
  logic [DW-1:0] AluData;
  logic          MemValid;
  logic          MemReady;
  logic [AW-1:0] MemReg;
  logic [DW-1:0] MemData;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ReadReg1;
  logic [AW-1:0] ReadReg2;
  logic [DW-1:0] RfData1;
  logic [DW-1:0] RfData2;
  logic [DW-1:0] FwdData1;
  logic [DW-1:0] FwdData2;
  logic          Pending;

  modport master (
    output AluValid, AluReg, AluData, MemValid, MemReg, MemData,
    output ReadReg1, ReadReg2, RfData1, RfData2,
    input  AluReady, MemReady, RegWrite, WriteReg, WriteData,
    input  FwdData1, FwdData2, Pending
  );

  modport slave (
    input  AluValid, AluReg, AluData, MemValid, MemReg, MemData,
    input  ReadReg1, ReadReg2, RfData1, RfData2,
    output AluReady, MemReady, RegWrite, WriteReg, WriteData,
    output FwdData1, FwdData2, Pending
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order write-back queue for the 32x32 register file, with read forwarding.
// Optional WB_STATS_EN adds saturating WbCount / StallCount outputs.
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  reg_writeback_queue_if.slave  bus
`ifdef WB_STATS_EN
  ,
  output logic [31:0]           WbCount,
  output logic [31:0]           StallCount
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] reg_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [AW-1:0] last_reg;
  logic [DW-1:0] last_data;

  logic alu_need, mem_need, alu_push, mem_push, pop, empty;

  // Writes to $0 take no slot: they are acknowledged and silently dropped.
  always_comb begin
    empty        = (count == '0);
    pop          = !empty;
    alu_need     = bus.AluValid && (bus.AluReg != '0);
    mem_need     = bus.MemValid && (bus.MemReg != '0);
    bus.AluReady = (count < CW'(DEPTH));
    bus.MemReady = ((count + CW'(alu_need)) < CW'(DEPTH));
    alu_push     = alu_need && bus.AluReady;
    mem_push     = mem_need && bus.MemReady;
    bus.RegWrite = !empty;
    bus.Pending  = !empty;
    bus.WriteReg  = empty ? last_reg  : reg_q[head];
    bus.WriteData = empty ? last_data : data_q[head];
  end

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    bus.FwdData1 = bus.RfData1;
    bus.FwdData2 = bus.RfData2;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if ((bus.ReadReg1 != '0) && (reg_q[head + PW'(i)] == bus.ReadReg1))
          bus.FwdData1 = data_q[head + PW'(i)];
        if ((bus.ReadReg2 != '0) && (reg_q[head + PW'(i)] == bus.ReadReg2))
          bus.FwdData2 = data_q[head + PW'(i)];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      last_reg  <= '0;
      last_data <= '0;
    end else begin
      if (pop) begin
        head      <= head + PW'(1);
        last_reg  <= reg_q[head];
        last_data <= data_q[head];
      end
      tail  <= tail + PW'(alu_push) + PW'(mem_push);
      count <= count + CW'(alu_push) + CW'(mem_push) - CW'(pop);
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by count.
  always_ff @(posedge Clk) begin
    if (alu_push) begin
      reg_q[tail]  <= bus.AluReg;
      data_q[tail] <= bus.AluData;
    end
    if (mem_push) begin
      reg_q[tail + PW'(alu_push)]  <= bus.MemReg;
      data_q[tail + PW'(alu_push)] <= bus.MemData;
    end
  end

`ifdef WB_STATS_EN
  logic stall;

  always_comb begin
    stall = (bus.AluValid && !bus.AluReady) || (bus.MemValid && !bus.MemReady);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      WbCount    <= '0;
      StallCount <= '0;
    end else begin
      if (pop && (WbCount != '1))
        WbCount <= WbCount + 32'd1;
      if (stall && (StallCount != '1))
        StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: directed scenarios, then random traffic
// checked against a queue-level model of occupancy, write order and forwarding.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } entry_t;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;

  reg_writeback_queue_if #(.AW(AW), .DW(DW)) bus ();

`ifdef WB_STATS_EN
  logic [31:0] WbCount;
  logic [31:0] StallCount;
`endif

  reg_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .bus        (bus.slave)
`ifdef WB_STATS_EN
    ,
    .WbCount    (WbCount),
    .StallCount (StallCount)
`endif
  );

  always #5 Clk = ~Clk;

  entry_t        occ[$];
  entry_t        sb[$];
  int            checks = 0;
  int            errors = 0;
  bit            done   = 1'b0;
  logic [AW-1:0] last_reg  = '0;
  logic [DW-1:0] last_data = '0;
  int            exp_wb    = 0;
  int            exp_stall = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fwdModel(input logic [AW-1:0] rr, input logic [DW-1:0] rf);
    logic [DW-1:0] v;
    v = rf;
    if (rr != '0)
      foreach (occ[i])
        if (occ[i].r == rr) v = occ[i].d;
    return v;
  endfunction

  // One clock cycle: drive at negedge, check combinational outputs, update model at posedge.
  task automatic applyStimulus(input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                               input bit mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bit exp_ar, exp_mr;
    int cnt;
    @(negedge Clk);
    bus.AluValid = av;  bus.AluReg = ar;  bus.AluData = ad;
    bus.MemValid = mv;  bus.MemReg = mr;  bus.MemData = md;
    bus.ReadReg1 = r1;  bus.ReadReg2 = r2;
    bus.RfData1  = DW'($urandom);
    bus.RfData2  = DW'($urandom);
    #1;
    cnt    = occ.size();
    exp_ar = (cnt < DEPTH);
    exp_mr = ((cnt + ((av && ar != '0) ? 1 : 0)) < DEPTH);
    checkOutput("AluReady", 32'(bus.AluReady), 32'(exp_ar));
    checkOutput("MemReady", 32'(bus.MemReady), 32'(exp_mr));
    checkOutput("Pending",  32'(bus.Pending),  32'(cnt != 0));
    checkOutput("FwdData1", bus.FwdData1, fwdModel(r1, bus.RfData1));
    checkOutput("FwdData2", bus.FwdData2, fwdModel(r2, bus.RfData2));
    @(posedge Clk);
    if (occ.size() != 0) begin
      void'(occ.pop_front());
      exp_wb++;
    end
    if ((av && !exp_ar) || (mv && !exp_mr)) exp_stall++;
    if (av && exp_ar && ar != '0) begin
      occ.push_back('{r: ar, d: ad});
      sb.push_back('{r: ar, d: ad});
    end
    if (mv && exp_mr && mr != '0) begin
      occ.push_back('{r: mr, d: md});
      sb.push_back('{r: mr, d: md});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, '0, '0, '0);
  endtask

  // Asynchronous reset taken in the middle of the high phase; queued entries are lost.
  task automatic resetPulse;
    #2;
    Rst_n = 1'b0;
    bus.AluValid = 1'b0;
    bus.MemValid = 1'b0;
    #1;
    checkOutput("rst_RegWrite",  32'(bus.RegWrite), 32'd0);
    checkOutput("rst_Pending",   32'(bus.Pending),  32'd0);
    checkOutput("rst_WriteReg",  32'(bus.WriteReg), 32'd0);
    checkOutput("rst_WriteData", bus.WriteData,     32'd0);
    checkOutput("rst_AluReady",  32'(bus.AluReady), 32'd1);
    checkOutput("rst_MemReady",  32'(bus.MemReady), 32'd1);
    occ.delete();
    sb.delete();
    last_reg  = '0;
    last_data = '0;
    exp_wb    = 0;
    exp_stall = 0;
    @(negedge Clk);
    #2;
    Rst_n = 1'b1;
`ifdef WB_STATS_EN
    checkOutput("rst_WbCount",    WbCount,    32'd0);
    checkOutput("rst_StallCount", StallCount, 32'd0);
`endif
  endtask

  // Monitor: every write must match the oldest outstanding accepted entry.
  initial begin
    entry_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n && !done) begin
        checkOutput("RegWrite", 32'(bus.RegWrite), 32'(sb.size() != 0));
        if (bus.RegWrite && sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("WriteReg",  32'(bus.WriteReg), 32'(e.r));
          checkOutput("WriteData", bus.WriteData,     e.d);
          last_reg  = e.r;
          last_data = e.d;
        end else if (!bus.RegWrite) begin
          checkOutput("hold_WriteReg",  32'(bus.WriteReg), 32'(last_reg));
          checkOutput("hold_WriteData", bus.WriteData,     last_data);
        end
      end
    end
  end

  initial begin
    bus.AluValid = 1'b0; bus.AluReg = '0; bus.AluData = '0;
    bus.MemValid = 1'b0; bus.MemReg = '0; bus.MemData = '0;
    bus.ReadReg1 = '0;   bus.ReadReg2 = '0;
    bus.RfData1  = '0;   bus.RfData2  = '0;
    resetPulse();

    applyStimulus(1, 5'd8, 32'h1234, 0, '0, '0, '0, '0);
    idle(2);

    applyStimulus(1, 5'd3, 32'hA, 1, 5'd3, 32'hB, '0, '0);
    applyStimulus(0, '0, '0, 0, '0, '0, 5'd3, 5'd3);
    idle(2);

    for (int i = 0; i < 5; i++)
      applyStimulus(1, AW'($urandom_range(1, 31)), DW'($urandom),
                    1, AW'($urandom_range(1, 31)), DW'($urandom),
                    AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
    idle(4);

    applyStimulus(1, 5'd0, 32'hFFFF, 1, 5'd5, 32'h55, 5'd0, 5'd5);
    idle(2);

    applyStimulus(1, 5'd9, 32'h900, 1, 5'd10, 32'hA00, '0, '0);
    applyStimulus(1, 5'd11, 32'hB00, 1, 5'd12, 32'hC00, 5'd10, 5'd11);
    resetPulse();
    idle(2);

    applyStimulus(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, '0, '0);
    applyStimulus(1, 5'd3, 32'h3, 1, 5'd4, 32'h4, '0, '0);
    applyStimulus(1, 5'd5, 32'h5, 1, 5'd6, 32'h6, '0, '0);
    applyStimulus(1, 5'd7, 32'h7, 1, 5'd8, 32'h8, '0, '0);
    idle(4);
`ifdef WB_STATS_EN
    checkOutput("WbCount",    WbCount,    32'(exp_wb));
    checkOutput("StallCount", StallCount, 32'(exp_stall));
`endif

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), DW'($urandom),
                    $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), DW'($urandom),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      if (i == 200) resetPulse();
    end
    idle(6);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifdef WB_STATS_EN
    checkOutput("WbCount_final",    WbCount,    32'(exp_wb));
    checkOutput("StallCount_final", StallCount, 32'(exp_stall));
`endif
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
